// File: rtl/vga_plot_sink.sv
// Plot sink between a pixel-drawing engine and a framebuffer write port.
// Buffers in-range plots in a small FIFO and keeps running drawing statistics.
module vga_plot_sink #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_stats,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic [14:0] pix_count,
    output logic [7:0]  oob_count,
    output logic [7:0]  bbox_xmin,
    output logic [7:0]  bbox_xmax,
    output logic [6:0]  bbox_ymin,
    output logic [6:0]  bbox_ymax,
    output logic        bbox_valid,
    output logic        overflow,
    output logic        idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [8:0]       W_LIM   = 9'(SCREEN_W);
    localparam logic [7:0]       H_LIM   = 8'(SCREEN_H);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;

    state_t            state_reg, state_next;
    logic [17:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [14:0] pix_count_reg;
    logic [7:0]  oob_count_reg;
    logic [7:0]  bbox_xmin_reg, bbox_xmax_reg;
    logic [6:0]  bbox_ymin_reg, bbox_ymax_reg;
    logic        bbox_valid_reg, overflow_reg;

    logic        in_range, plot_in, plot_oob, push, pop, dropped;
    logic [14:0] plot_addr;
    logic [17:0] head;

    assign in_range  = ({1'b0, vga_x} < W_LIM) && ({1'b0, vga_y} < H_LIM);
    assign plot_in   = vga_plot && in_range;
    assign plot_oob  = vga_plot && !in_range;
    assign plot_addr = 15'(vga_y) * 15'(SCREEN_W) + 15'(vga_x);
    assign head      = fifo_mem[rd_ptr_reg];

    assign pop     = fb_we && fb_ready;
    // A full FIFO still takes a new pixel when the head leaves on the same edge.
    assign push    = plot_in && ((count_reg < DEPTH_C) || pop);
    assign dropped = plot_in && !push;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Looking at the post-edge occupancy lets a fresh pixel reach fb_we next cycle.
    always_comb begin
        state_next = state_reg;
        fb_we      = 1'b0;
        fb_addr    = 15'd0;
        fb_data    = 3'd0;
        case (state_reg)
            ST_IDLE: begin
                if (count_next != '0) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                fb_we   = 1'b1;
                fb_addr = head[17:3];
                fb_data = head[2:0];
                if (count_next == '0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) begin
                fifo_mem[wr_ptr_reg] <= {plot_addr, vga_colour};
                wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            pix_count_reg  <= '0;
            oob_count_reg  <= '0;
            bbox_xmin_reg  <= '0;
            bbox_xmax_reg  <= '0;
            bbox_ymin_reg  <= '0;
            bbox_ymax_reg  <= '0;
            bbox_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (plot_oob && oob_count_reg != 8'hff)
                oob_count_reg <= oob_count_reg + 8'd1;
            if (dropped)
                overflow_reg <= 1'b1;
            if (push && pix_count_reg != 15'h7fff)
                pix_count_reg <= pix_count_reg + 15'd1;
            if (push && vga_colour != 3'b000) begin
                bbox_valid_reg <= 1'b1;
                if (!bbox_valid_reg) begin
                    bbox_xmin_reg <= vga_x;
                    bbox_xmax_reg <= vga_x;
                    bbox_ymin_reg <= vga_y;
                    bbox_ymax_reg <= vga_y;
                end else begin
                    if (vga_x < bbox_xmin_reg) bbox_xmin_reg <= vga_x;
                    if (vga_x > bbox_xmax_reg) bbox_xmax_reg <= vga_x;
                    if (vga_y < bbox_ymin_reg) bbox_ymin_reg <= vga_y;
                    if (vga_y > bbox_ymax_reg) bbox_ymax_reg <= vga_y;
                end
            end
        end
    end

    assign pix_count  = pix_count_reg;
    assign oob_count  = oob_count_reg;
    assign bbox_xmin  = bbox_xmin_reg;
    assign bbox_xmax  = bbox_xmax_reg;
    assign bbox_ymin  = bbox_ymin_reg;
    assign bbox_ymax  = bbox_ymax_reg;
    assign bbox_valid = bbox_valid_reg;
    assign overflow   = overflow_reg;
    assign idle       = (count_reg == '0) && !fb_we;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Scoreboard bench for vga_plot_sink: expected framebuffer writes are queued
// by the stimulus and popped by a monitor on every accepted transfer.
module tb_vga_plot_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_stats;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic [14:0] pix_count;
    logic [7:0]  oob_count;
    logic [7:0]  bbox_xmin, bbox_xmax;
    logic [6:0]  bbox_ymin, bbox_ymax;
    logic        bbox_valid, overflow, idle;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q [$];
    logic [17:0] exp_w;

    vga_plot_sink dut (
        .clk(clk), .rst(rst),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .clear_stats(clear_stats),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
        .pix_count(pix_count), .oob_count(oob_count),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .bbox_valid(bbox_valid), .overflow(overflow), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One plot cycle; expect_write queues the framebuffer write it should cause.
    task automatic plot(input int x, input int y, input int c, input bit expect_write);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
        if (expect_write) exp_q.push_back({15'(y * 160 + x), 3'(c)});
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!idle && n < 40) begin
            tick();
            n++;
        end
        check(name, int'(idle), 1);
    endtask

    // Monitor: every transfer (fb_we && fb_ready) must match the queue head.
    always @(negedge clk) begin
        if (!rst && fb_we && fb_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                         fb_addr, fb_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({fb_addr, fb_data} != exp_w) begin
                    errors++;
                    $display("FAIL fb_write: got addr %0d data %0d, required addr %0d data %0d",
                             fb_addr, fb_data, exp_w[17:3], exp_w[2:0]);
                end else begin
                    $display("write addr %0d data %0d", fb_addr, fb_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0;
        vga_plot = 1'b0; clear_stats = 1'b0; fb_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_fb_we", int'(fb_we), 0);
        check("reset_fb_addr", int'(fb_addr), 0);
        check("reset_fb_data", int'(fb_data), 0);
        check("reset_idle", int'(idle), 1);
        check("reset_pix", int'(pix_count), 0);
        check("reset_oob", int'(oob_count), 0);
        check("reset_bbox_valid", int'(bbox_valid), 0);
        check("reset_overflow", int'(overflow), 0);

        // Single pixel: write visible the cycle after acceptance
        plot(10, 40, 2, 1);
        check("lat_fb_we", int'(fb_we), 1);
        check("lat_fb_addr", int'(fb_addr), 6410);
        check("lat_fb_data", int'(fb_data), 2);
        check("single_pix", int'(pix_count), 1);
        check("single_xmin", int'(bbox_xmin), 10);
        check("single_xmax", int'(bbox_xmax), 10);
        check("single_ymin", int'(bbox_ymin), 40);
        check("single_ymax", int'(bbox_ymax), 40);
        check("single_valid", int'(bbox_valid), 1);
        wait_idle("single_idle");
        clear();

        // Out-of-range plots on both boundaries
        plot(160, 5, 1, 0);
        check("oob1_idle", int'(idle), 1);
        plot(3, 120, 1, 0);
        check("oob2_idle", int'(idle), 1);
        check("oob_count", int'(oob_count), 2);
        check("oob_pix", int'(pix_count), 0);
        check("oob_fb_we", int'(fb_we), 0);
        clear();
        check("clear_oob", int'(oob_count), 0);

        // Overflow with stalled framebuffer
        fb_ready = 1'b0;
        for (int i = 0; i < 6; i++) plot(i, 1, 3, i < 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_pix", int'(pix_count), 4);
        tick(); tick();
        check("stall_fb_we", int'(fb_we), 1);
        check("stall_fb_addr", int'(fb_addr), 160);
        check("stall_fb_data", int'(fb_data), 3);
        fb_ready = 1'b1;
        wait_idle("ovf_drain_idle");
        check("ovf_drain_queue", exp_q.size(), 0);
        clear();
        check("clear_overflow", int'(overflow), 0);

        // Full FIFO accepts a plot on the pop cycle
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) plot(20 + i, 2, 1, 1);
        fb_ready = 1'b1;
        plot(30, 2, 5, 1);
        check("fullpop_overflow", int'(overflow), 0);
        check("fullpop_pix", int'(pix_count), 5);
        wait_idle("fullpop_idle");
        clear();

        // Bounding box ignores black; extreme address
        plot(5, 5, 0, 1);
        plot(20, 30, 4, 1);
        plot(80, 10, 4, 1);
        check("bbox_xmin", int'(bbox_xmin), 20);
        check("bbox_xmax", int'(bbox_xmax), 80);
        check("bbox_ymin", int'(bbox_ymin), 10);
        check("bbox_ymax", int'(bbox_ymax), 30);
        check("bbox_pix", int'(pix_count), 3);
        check("bbox_valid", int'(bbox_valid), 1);
        plot(159, 119, 7, 1);
        check("corner_xmax", int'(bbox_xmax), 159);
        check("corner_ymax", int'(bbox_ymax), 119);
        wait_idle("bbox_idle");
        clear();
        check("clr_pix", int'(pix_count), 0);
        check("clr_valid", int'(bbox_valid), 0);
        check("clr_xmax", int'(bbox_xmax), 0);
        check("clr_ymax", int'(bbox_ymax), 0);

        // Plot on the clear cycle is written but not counted
        clear_stats = 1'b1;
        plot(1, 0, 1, 1);
        clear_stats = 1'b0;
        check("clrplot_pix", int'(pix_count), 0);
        check("clrplot_valid", int'(bbox_valid), 0);
        wait_idle("clrplot_idle");

        // Reset with a write in flight and entries pending
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) plot(50 + i, 50, 6, 0);
        check("prerst_fb_we", int'(fb_we), 1);
        check("prerst_queue", exp_q.size(), 0);
        rst = 1'b1;
        plot(7, 7, 2, 0);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_pix", int'(pix_count), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        rst = 1'b0;
        fb_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("postrst_idle", int'(idle), 1);
        check("postrst_pix", int'(pix_count), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_plot_sink.md
VGA_PLOT_SINK -- requirements
Module: vga_plot_sink

Interface
REQ-001 Parameter SCREEN_W, default 160, visible columns.
REQ-002 Parameter SCREEN_H, default 120, visible rows.
REQ-003 Parameter FIFO_DEPTH, default 4, pending-write entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 vga_x  input  8  plot column from drawing engine.
REQ-007 vga_y  input  7  plot row.
REQ-008 vga_colour  input  3  plot colour.
REQ-009 vga_plot  input  1  plot strobe, one pixel per high cycle; no backpressure to producer.
REQ-010 clear_stats  input  1  one-cycle pulse clearing statistics.
REQ-011 fb_addr  output  15  framebuffer word address.
REQ-012 fb_data  output  3  framebuffer write colour.
REQ-013 fb_we  output  1  write request; held until accepted.
REQ-014 fb_ready  input  1  framebuffer accepts write this cycle.
REQ-015 pix_count  output  15  accepted in-range pixels, saturating at 32767.
REQ-016 oob_count  output  8  out-of-range plots, saturating at 255.
REQ-017 bbox_xmin/bbox_xmax  output  8 each  bounding box columns of non-black pixels.
REQ-018 bbox_ymin/bbox_ymax  output  7 each  bounding box rows of non-black pixels.
REQ-019 bbox_valid  output  1  at least one non-black pixel since last clear.
REQ-020 overflow  output  1  sticky: an in-range pixel was dropped on full FIFO.
REQ-021 idle  output  1  FIFO empty and fb_we low.

Function
REQ-022 Plot sampled on rising edge with vga_plot=1; in-range iff vga_x<SCREEN_W and vga_y<SCREEN_H.
REQ-023 Out-of-range plot: not enqueued, oob_count increments (saturating), no other effect.
REQ-024 In-range plot enqueued as {address, colour}; address = vga_y*SCREEN_W + vga_x, computed at full 15-bit width (max 19199).
REQ-025 Push accepted if FIFO count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same cycle.
REQ-026 Otherwise in-range pixel dropped, overflow set, pix_count/bbox not updated.
REQ-027 Write FSM states IDLE and WRITE; IDLE->WRITE when FIFO non-empty; WRITE drives fb_we=1 with fb_addr/fb_data from FIFO head.
REQ-028 Transfer completes on a cycle with fb_we=1 and fb_ready=1; head popped that edge; FSM stays WRITE if more entries remain, else returns to IDLE.
REQ-029 fb_addr/fb_data stable while fb_we=1 and fb_ready=0.
REQ-030 Latency: plot accepted at edge N into empty FIFO -> fb_we=1 during cycle N+1; with fb_ready held high, sustained throughput one write per cycle.
REQ-031 Writes issued in acceptance order; no merging or reordering of equal addresses.
REQ-032 pix_count increments on every accepted push.
REQ-033 bbox updated on accepted push with colour!=3'b000: first such pixel loads min=max=(x,y) and sets bbox_valid; later ones widen min/max.
REQ-034 clear_stats zeroes pix_count, oob_count, overflow, bbox_* and bbox_valid; a same-cycle plot is still enqueued/written but excluded from statistics; FIFO and FSM unaffected.

Reset
REQ-035 rst=1 at an edge: FIFO flushed, FSM to IDLE, in-flight write abandoned, fb_we=0, fb_addr=0, fb_data=0, all counts/bbox/bbox_valid/overflow=0, idle=1.
REQ-036 rst overrides vga_plot and clear_stats in the same cycle; first plot accepted on the edge after rst deasserts.

Verification
REQ-037 fb_ready=1, plot (10,40,colour 2) -> next cycle fb_we=1, fb_addr=6410, fb_data=2; pix_count=1; bbox=(10..10,40..40), bbox_valid=1.
REQ-038 Plots (160,5) and (3,120) -> oob_count=2, no fb_we, pix_count=0, idle stays 1.
REQ-039 fb_ready=0, six consecutive in-range plots -> four stored, overflow=1, pix_count=4; raise fb_ready -> exactly four writes in order, then idle=1.
REQ-040 FIFO full, fb_ready=1, plot on pop cycle -> accepted, overflow stays 0.
REQ-041 Plots (5,5,black),(20,30,red),(80,10,red) -> bbox x 20..80, y 10..30, pix_count=3; clear_stats -> all stats 0, bbox_valid=0.
REQ-042 rst asserted with fb_we=1 and 3 entries pending -> next cycle fb_we=0, idle=1, all counts 0; no further writes.
